// File: rtl/ifetch_unit.sv
// LEGv8 instruction fetch: PC ownership, single-outstanding imem req/ack, and a small
// instruction queue toward decode. Optional macro IFETCH_PREDECODE_B_EN follows unconditional B.
module ifetch_unit #(
    parameter int              WORD       = 64,
    parameter int              INSTR_LEN  = 32,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [WORD-1:0] RESET_PC   = '0
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    output logic                 imem_req_o,
    output logic [WORD-1:0]      imem_addr_o,
    input  logic                 imem_ack_i,
    input  logic [INSTR_LEN-1:0] imem_rdata_i,
    output logic                 instr_valid_o,
    output logic [INSTR_LEN-1:0] instruction_o,
    output logic [WORD-1:0]      instr_pc_o,
    input  logic                 instr_ready_i,
    input  logic                 redirect_i,
    input  logic [WORD-1:0]      redirect_pc_i
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 req_q, req_d;
    logic [WORD-1:0]      addr_q, addr_d;
    logic [WORD-1:0]      target_q, target_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [INSTR_LEN-1:0] instr_mem_q [FIFO_DEPTH];
    logic [WORD-1:0]      pc_mem_q    [FIFO_DEPTH];

    logic            push, pop, free_d;
    logic [WORD-1:0] next_pc;
    logic [WORD-1:0] redirect_aligned;

    assign push             = (state_q == ST_FETCH) && req_q && imem_ack_i && !redirect_i;
    assign pop              = (count_q != '0) && instr_ready_i && !redirect_i;
    assign redirect_aligned = redirect_pc_i & ~WORD'(3);

    always_comb begin
        next_pc = addr_q + WORD'(4);
`ifdef IFETCH_PREDECODE_B_EN
        if (imem_rdata_i[31:26] == 6'b000101)
            next_pc = addr_q + {{(WORD-28){imem_rdata_i[25]}}, imem_rdata_i[25:0], 2'b00};
`endif
    end

    always_comb begin
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        if (redirect_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    assign free_d = (count_d < DEPTH_C);

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        target_d = target_q;
        if (redirect_i) begin
            // An un-acked request must still complete on the bus; its data is dropped in FLUSH.
            if (req_q && !imem_ack_i) begin
                state_d  = ST_FLUSH;
                target_d = redirect_aligned;
            end else begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                addr_d  = redirect_aligned;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (req_q && imem_ack_i) begin
                        addr_d  = next_pc;
                        req_d   = free_d;
                        state_d = free_d ? ST_FETCH : ST_FULL;
                    end else if (!req_q) begin
                        req_d   = free_d;
                        state_d = free_d ? ST_FETCH : ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (free_d) begin
                        req_d   = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
                ST_FLUSH: begin
                    if (imem_ack_i) begin
                        req_d   = 1'b1;
                        addr_d  = target_q;
                        state_d = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_FETCH;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            target_q <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            target_q <= target_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) begin
                instr_mem_q[wr_ptr_q] <= imem_rdata_i;
                pc_mem_q[wr_ptr_q]    <= addr_q;
            end
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = (count_q != '0);
    assign instruction_o = instr_mem_q[rd_ptr_q];
    assign instr_pc_o    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed cycle table, hand-written corner
// sequences, and a random run scored against a fetch-stream reference model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req, ack, valid, ready, redirect;
    logic [63:0] addr, ipc, rpc;
    logic [31:0] rdata, instr;

    int tests = 0;
    int fails = 0;

    int          ws = 0;
    bit          mem_rand = 1'b0;
    bit          stall_en = 1'b0;
    logic [63:0] stall_addr = '0;
    bit          b_override = 1'b0;

    always #5 clk = ~clk;

    ifetch_unit #(.WORD(64), .INSTR_LEN(32), .FIFO_DEPTH(2), .RESET_PC(64'd0)) dut (
        .clk_i         (clk),
        .reset_n_i     (rst_n),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_rdata_i  (rdata),
        .instr_valid_o (valid),
        .instruction_o (instr),
        .instr_pc_o    (ipc),
        .instr_ready_i (ready),
        .redirect_i    (redirect),
        .redirect_pc_i (rpc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] w;
        w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
        if (w[31:26] == 6'b000101) w[31] = ~w[31];
        if (b_override && a == 64'h20) w = 32'h1400_0004;
        return w;
    endfunction

    // Memory responder: acks after ws idle cycles, checks address stability while pending.
    initial begin : responder
        int          cnt;
        bit          pend;
        logic [63:0] paddr;
        cnt = 0; pend = 1'b0; paddr = '0;
        ack = 1'b0; rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n || !req) begin
                ack = 1'b0; rdata = 32'hDEAD_BEEF; cnt = 0; pend = 1'b0;
            end else begin
                if (pend) check("addr_stable", addr, paddr);
                if (stall_en && addr == stall_addr) begin
                    ack = 1'b0; rdata = 32'hDEAD_BEEF; pend = 1'b1; paddr = addr;
                end else if (cnt >= ws) begin
                    ack = 1'b1; rdata = mem_word(addr); cnt = 0; pend = 1'b0;
                    if (mem_rand) ws = $urandom_range(0, 3);
                end else begin
                    ack = 1'b0; rdata = 32'hDEAD_BEEF; cnt++; pend = 1'b1; paddr = addr;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        ready = 1'b0; redirect = 1'b0; rpc = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", req, 0);
        check("rst_addr", addr, 0);
        check("rst_valid", valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", ipc, 0);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          rdy;
        bit          redir;
        logic [63:0] rpc;
        bit          e_req;
        logic [63:0] e_addr;
        bit          e_valid;
        logic [63:0] e_pc;
    } vec_t;

    function automatic vec_t mk(bit r, bit d, logic [63:0] p, bit eq, logic [63:0] ea,
                                bit ev, logic [63:0] ep);
        vec_t v;
        v.rdy = r; v.redir = d; v.rpc = p; v.e_req = eq; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    vec_t tbl [17];

    initial begin : main
        int          n;
        bit          found;
        int          last_pop;
        logic [63:0] exp_pc;
        bit          prev_redir;
        bit          r, rd;
        logic [63:0] rp;
        int          pops;

        // Zero-wait memory; ready drops for 5 cycles; redirect collides with ack and pop.
        tbl[0]  = mk(1, 0, 0,      1, 64'd0,   0, 0);
        tbl[1]  = mk(1, 0, 0,      1, 64'd4,   1, 64'd0);
        tbl[2]  = mk(1, 0, 0,      1, 64'd8,   1, 64'd4);
        tbl[3]  = mk(1, 0, 0,      1, 64'd12,  1, 64'd8);
        tbl[4]  = mk(0, 0, 0,      1, 64'd16,  1, 64'd12);
        tbl[5]  = mk(0, 0, 0,      0, 64'd20,  1, 64'd12);
        tbl[6]  = mk(0, 0, 0,      0, 64'd20,  1, 64'd12);
        tbl[7]  = mk(0, 0, 0,      0, 64'd20,  1, 64'd12);
        tbl[8]  = mk(0, 0, 0,      0, 64'd20,  1, 64'd12);
        tbl[9]  = mk(1, 0, 0,      0, 64'd20,  1, 64'd12);
        tbl[10] = mk(1, 0, 0,      1, 64'd20,  1, 64'd16);
        tbl[11] = mk(1, 0, 0,      1, 64'd24,  1, 64'd20);
        tbl[12] = mk(1, 0, 0,      1, 64'd28,  1, 64'd24);
        tbl[13] = mk(1, 0, 0,      1, 64'd32,  1, 64'd28);
        tbl[14] = mk(1, 1, 64'h103, 1, 64'd36, 1, 64'd32);
        tbl[15] = mk(1, 0, 0,      1, 64'h100, 0, 0);
        tbl[16] = mk(1, 0, 0,      1, 64'h104, 1, 64'h100);

        ws = 0;
        do_reset();
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            check($sformatf("tbl%0d_req", k), req, tbl[k].e_req);
            check($sformatf("tbl%0d_addr", k), addr, tbl[k].e_addr);
            check($sformatf("tbl%0d_valid", k), valid, tbl[k].e_valid);
            if (tbl[k].e_valid) begin
                check($sformatf("tbl%0d_pc", k), ipc, tbl[k].e_pc);
                check($sformatf("tbl%0d_instr", k), instr, mem_word(tbl[k].e_pc));
            end
            ready = tbl[k].rdy; redirect = tbl[k].redir; rpc = tbl[k].rpc;
        end

        // Redirect while request to 0x40 is held off by memory.
        do_reset();
        ws = 0; stall_addr = 64'h40; stall_en = 1'b1; ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (req && addr == 64'h40) found = 1'b1;
        end
        check("pend40_reached", found, 1);
        redirect = 1'b1; rpc = 64'h103;
        @(negedge clk);
        redirect = 1'b0; stall_en = 1'b0;
        check("flush_req", req, 1);
        check("flush_addr", addr, 64'h40);
        check("flush_valid", valid, 0);
        @(negedge clk);
        check("refetch_req", req, 1);
        check("refetch_addr", addr, 64'h100);
        check("refetch_valid", valid, 0);
        @(negedge clk);
        check("redir_valid", valid, 1);
        check("redir_pc", ipc, 64'h100);
        check("redir_instr", instr, mem_word(64'h100));

        // Second redirect while already in FLUSH replaces the target.
        stall_addr = 64'h110; stall_en = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            @(negedge clk);
            if (req && addr == 64'h110) found = 1'b1;
        end
        check("pend110_reached", found, 1);
        redirect = 1'b1; rpc = 64'h300;
        @(negedge clk);
        check("flush2_addr", addr, 64'h110);
        redirect = 1'b1; rpc = 64'h403;
        @(negedge clk);
        check("flush2_hold", addr, 64'h110);
        check("flush2_valid", valid, 0);
        redirect = 1'b0; stall_en = 1'b0;
        @(negedge clk);
        check("flush2_target", addr, 64'h400);
        check("flush2_target_req", req, 1);
        @(negedge clk);
        check("flush2_pc", ipc, 64'h400);
        check("flush2_vld", valid, 1);

        // Three wait states: one instruction every four cycles.
        do_reset();
        ws = 3; ready = 1'b1;
        n = 0; last_pop = 0;
        for (int k = 0; k < 60 && n < 5; k++) begin
            @(negedge clk);
            if (valid) begin
                check("ws3_pc", ipc, 64'(4 * n));
                if (n > 0) check("ws3_gap", 64'(k - last_pop), 64'd4);
                last_pop = k;
                n++;
            end
        end
        check("ws3_count", 64'(n), 64'd5);
        ws = 0;

        // Unconditional B predecode at 0x20.
        b_override = 1'b1;
        do_reset();
        ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (req && addr == 64'h20) found = 1'b1;
        end
        check("b_reached", found, 1);
        @(negedge clk);
`ifdef IFETCH_PREDECODE_B_EN
        check("b_next_addr", addr, 64'h30);
`else
        check("b_next_addr", addr, 64'h24);
`endif
        check("b_head_pc", ipc, 64'h20);
        check("b_head_instr", instr, 64'h1400_0004);
        b_override = 1'b0;

        // Random: the delivered stream must be consecutive words from the latest redirect target.
        do_reset();
        mem_rand = 1'b1; ws = $urandom_range(0, 3);
        exp_pc = '0; prev_redir = 1'b0; pops = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (prev_redir) check("rnd_valid_after_redirect", valid, 0);
            r  = (i == 5) ? 1'b1 : (i > 60 && $urandom_range(0, 24) == 0);
            rp = (i == 5) ? 64'hFFFF_FFFF_FFFF_FFF6 : {$urandom, $urandom};
            rd = ($urandom_range(0, 3) != 0);
            if (valid && rd && !r) begin
                check("rnd_pc", ipc, exp_pc);
                check("rnd_instr", instr, mem_word(exp_pc));
                exp_pc = exp_pc + 64'd4;
                pops++;
            end
            if (r) exp_pc = rp & ~64'd3;
            ready = rd; redirect = r; rpc = rp; prev_redir = r;
        end
        redirect = 1'b0; mem_rand = 1'b0; ws = 0;
        check("rnd_progress", 64'(pops > 200), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
